// File: rtl/find_scheduler.sv
// Job scheduler for a bank of search units: slices an inclusive sequence range into
// chunks, dispatches them round-robin and merges per-unit minimum-energy results.
module find_scheduler #(
    parameter int SEQ_WIDTH      = 16,
    parameter int E_WIDTH        = 16,
    parameter int PARALLEL_UNITS = 2
) (
    input  logic                                wb_clk_i,
    input  logic                                wb_rst_i,
    input  logic                                cfg_start_i,
    input  logic                                cfg_abort_i,
    input  logic [SEQ_WIDTH-1:0]                cfg_first_i,
    input  logic [SEQ_WIDTH-1:0]                cfg_last_i,
    input  logic [SEQ_WIDTH-1:0]                cfg_chunk_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                err_o,
    output logic                                aborted_o,
    output logic [SEQ_WIDTH-1:0]                best_seq_o,
    output logic [E_WIDTH-1:0]                  best_e_o,
    output logic [PARALLEL_UNITS-1:0]           unit_start_o,
    output logic [PARALLEL_UNITS*SEQ_WIDTH-1:0] unit_seq_o,
    output logic [PARALLEL_UNITS*SEQ_WIDTH-1:0] unit_len_o,
    input  logic [PARALLEL_UNITS-1:0]           unit_idle_i,
    input  logic [PARALLEL_UNITS-1:0]           unit_done_i,
    input  logic [PARALLEL_UNITS*SEQ_WIDTH-1:0] unit_best_seq_i,
    input  logic [PARALLEL_UNITS*E_WIDTH-1:0]   unit_best_e_i,
    output logic [PARALLEL_UNITS-1:0]           unit_ack_o,
    output logic [1:0]                          dbg_state_o
);

    localparam int N  = PARALLEL_UNITS;
    localparam int SW = SEQ_WIDTH;
    localparam int EW = E_WIDTH;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPATCH = 2'd1,
        S_DRAIN    = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            aborted_q, aborted_d;
    logic            abort_req_q, abort_req_d;
    logic [SW-1:0]   best_seq_q, best_seq_d;
    logic [EW-1:0]   best_e_q, best_e_d;
    logic [SW:0]     next_q, next_d;
    logic [SW-1:0]   last_q, last_d;
    logic [SW-1:0]   chunk_q, chunk_d;
    logic [N-1:0]    mask_q, mask_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [N-1:0]    ustart_q, ustart_d;
    logic [N*SW-1:0] useq_q, useq_d;
    logic [N*SW-1:0] ulen_q, ulen_d;

    logic [N-1:0]    cand;
    logic [N-1:0]    disp_oh;
    logic            disp_found;
    logic [IW-1:0]   rr_next;
    logic [N-1:0]    ack;
    logic            ack_found;
    logic            rec_hit;
    logic [EW-1:0]   rec_e;
    logic [SW-1:0]   rec_s;
    logic            better;
    logic [SW:0]     remain;
    logic [SW-1:0]   len;
    logic            do_disp;

    // Unit handshake: unit_start_o with unit_seq_o/unit_len_o is a registered one-cycle
    // command. unit_ack_o is raised combinationally in the cycle the held result
    // (unit_done_i level) is merged; the unit drops unit_done_i on the edge it sees ack.

    // Round-robin: first pass covers rr_q..N-1, second pass wraps to 0..rr_q-1.
    always_comb begin
        cand       = unit_idle_i & ~mask_q;
        disp_oh    = '0;
        disp_found = 1'b0;
        rr_next    = rr_q;
        for (int k = 0; k < N; k++) begin
            if (!disp_found && cand[k] && (k >= int'(rr_q))) begin
                disp_found = 1'b1;
                disp_oh[k] = 1'b1;
                rr_next    = (k == N - 1) ? '0 : IW'(k + 1);
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!disp_found && cand[k]) begin
                disp_found = 1'b1;
                disp_oh[k] = 1'b1;
                rr_next    = (k == N - 1) ? '0 : IW'(k + 1);
            end
        end
    end

    always_comb begin
        ack       = '0;
        ack_found = 1'b0;
        rec_hit   = 1'b0;
        rec_e     = '0;
        rec_s     = '0;
        if (state_q == S_DISPATCH || state_q == S_DRAIN) begin
            for (int k = 0; k < N; k++) begin
                if (!ack_found && unit_done_i[k]) begin
                    ack_found = 1'b1;
                    ack[k]    = 1'b1;
                    rec_hit   = mask_q[k];
                    rec_e     = unit_best_e_i[k*EW +: EW];
                    rec_s     = unit_best_seq_i[k*SW +: SW];
                end
            end
        end
    end

    assign better = rec_hit && ((rec_e < best_e_q) ||
                                ((rec_e == best_e_q) && (rec_s < best_seq_q)));

    // Remaining span is SW+1 bits wide: a full-range job has 2^SW sequences left.
    assign remain = {1'b0, last_q} - next_q + {{SW{1'b0}}, 1'b1};
    assign len    = ({1'b0, chunk_q} < remain) ? chunk_q : remain[SW-1:0];

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        aborted_d   = aborted_q;
        abort_req_d = abort_req_q;
        best_seq_d  = best_seq_q;
        best_e_d    = best_e_q;
        next_d      = next_q;
        last_d      = last_q;
        chunk_d     = chunk_q;
        mask_d      = mask_q & ~ack;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        ustart_d    = '0;
        useq_d      = useq_q;
        ulen_d      = ulen_q;
        do_disp     = 1'b0;

        if (better) begin
            best_e_d   = rec_e;
            best_seq_d = rec_s;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (cfg_start_i) begin
                    best_e_d    = '1;
                    best_seq_d  = '0;
                    err_d       = 1'b0;
                    aborted_d   = 1'b0;
                    abort_req_d = 1'b0;
                    next_d      = {1'b0, cfg_first_i};
                    last_d      = cfg_last_i;
                    chunk_d     = (cfg_chunk_i == '0) ? SW'(1) : cfg_chunk_i;
                    if (cfg_first_i > cfg_last_i) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DISPATCH;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                    end
                end
            end
            S_DISPATCH: begin
                if (cfg_abort_i) begin
                    abort_req_d = 1'b1;
                    state_d     = S_DRAIN;
                end else if (next_q > {1'b0, last_q}) begin
                    state_d = S_DRAIN;
                end else if (disp_found) begin
                    do_disp = 1'b1;
                end
            end
            S_DRAIN: begin
                if (cfg_abort_i) begin
                    abort_req_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d   = S_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    aborted_d = abort_req_d;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_disp) begin
            ustart_d = disp_oh;
            mask_d   = mask_d | disp_oh;
            next_d   = next_q + {1'b0, len};
            rr_d     = rr_next;
            for (int k = 0; k < N; k++) begin
                if (disp_oh[k]) begin
                    useq_d[k*SW +: SW] = next_q[SW-1:0];
                    ulen_d[k*SW +: SW] = len;
                end
            end
        end

        if (do_disp && !rec_hit) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!do_disp && rec_hit) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            aborted_q   <= 1'b0;
            abort_req_q <= 1'b0;
            best_seq_q  <= '0;
            best_e_q    <= '1;
            next_q      <= '0;
            last_q      <= '0;
            chunk_q     <= '0;
            mask_q      <= '0;
            cnt_q       <= '0;
            rr_q        <= '0;
            ustart_q    <= '0;
            useq_q      <= '0;
            ulen_q      <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            aborted_q   <= aborted_d;
            abort_req_q <= abort_req_d;
            best_seq_q  <= best_seq_d;
            best_e_q    <= best_e_d;
            next_q      <= next_d;
            last_q      <= last_d;
            chunk_q     <= chunk_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            ustart_q    <= ustart_d;
            useq_q      <= useq_d;
            ulen_q      <= ulen_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign aborted_o    = aborted_q;
    assign best_seq_o   = best_seq_q;
    assign best_e_o     = best_e_q;
    assign unit_start_o = ustart_q;
    assign unit_seq_o   = useq_q;
    assign unit_len_o   = ulen_q;
    assign unit_ack_o   = ack;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_find_scheduler.sv
// Bench for find_scheduler: behavioural search units answer dispatches; dispatches are
// checked against an expected queue and final results against hand-derived values.
module tb_find_scheduler;

    localparam int SW = 16;
    localparam int EW = 16;
    localparam int N  = 2;
    localparam int XW = 34;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_start, cfg_abort;
    logic [SW-1:0]   cfg_first, cfg_last, cfg_chunk;
    logic            busy_o, done_o, err_o, aborted_o;
    logic [SW-1:0]   best_seq_o;
    logic [EW-1:0]   best_e_o;
    logic [N-1:0]    unit_start_o;
    logic [N*SW-1:0] unit_seq_o, unit_len_o;
    logic [N-1:0]    u_idle = '0;
    logic [N-1:0]    u_done = '0;
    logic [N*SW-1:0] u_bseq = '0;
    logic [N*EW-1:0] u_be = '0;
    logic [N-1:0]    unit_ack_o;
    logic [1:0]      dbg_state_o;

    always #5 clk = ~clk;

    find_scheduler #(.SEQ_WIDTH(SW), .E_WIDTH(EW), .PARALLEL_UNITS(N)) dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst_n),
        .cfg_start_i     (cfg_start),
        .cfg_abort_i     (cfg_abort),
        .cfg_first_i     (cfg_first),
        .cfg_last_i      (cfg_last),
        .cfg_chunk_i     (cfg_chunk),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .aborted_o       (aborted_o),
        .best_seq_o      (best_seq_o),
        .best_e_o        (best_e_o),
        .unit_start_o    (unit_start_o),
        .unit_seq_o      (unit_seq_o),
        .unit_len_o      (unit_len_o),
        .unit_idle_i     (u_idle),
        .unit_done_i     (u_done),
        .unit_best_seq_i (u_bseq),
        .unit_best_e_i   (u_be),
        .unit_ack_o      (unit_ack_o),
        .dbg_state_o     (dbg_state_o)
    );

    logic [XW-1:0] exp_q[$];
    logic [31:0]   res_q[$];
    int            ack_log[$];
    int            n_chk = 0;
    int            n_pass = 0;
    int            cyc = 0;

    bit            ubusy[N] = '{0, 0};
    int            timer[N] = '{0, 0};
    bit            uen[N] = '{1, 1};
    int            lat[N] = '{3, 2};
    bit            stray_req[N] = '{0, 0};
    logic [31:0]   pend[N];
    logic [N-1:0]  ack_seen = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic expect_disp(input int u, input logic [SW-1:0] s, input logic [SW-1:0] l);
        exp_q.push_back({2'(u), s, l});
    endtask

    task automatic add_res(input logic [EW-1:0] e, input logic [SW-1:0] s);
        res_q.push_back({e, s});
    endtask

    task automatic start_job(input logic [SW-1:0] f, input logic [SW-1:0] l, input logic [SW-1:0] c);
        @(negedge clk);
        cfg_first = f;
        cfg_last  = l;
        cfg_chunk = c;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, done_o, 1'b1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        ack_seen = unit_ack_o;
        for (int k = 0; k < N; k++) begin
            if (unit_ack_o[k]) ack_log.push_back(cyc * 4 + k);
        end
    end

    // Unit model: accepts a chunk on unit_start_o, reports after lat cycles, holds until acked.
    initial forever begin
        logic [XW-1:0] got;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (!rst_n) begin
                ubusy[k]  = 1'b0;
                u_done[k] = 1'b0;
            end else begin
                if (ack_seen[k]) u_done[k] = 1'b0;
                if (unit_start_o[k]) begin
                    got = {2'(k), unit_seq_o[k*SW +: SW], unit_len_o[k*SW +: SW]};
                    if (exp_q.size() > 0) check("dispatch", got, exp_q.pop_front());
                    else check("dispatch_unexpected", unit_start_o[k], 1'b0);
                    pend[k]  = (res_q.size() > 0) ? res_q.pop_front() : 32'hFFFF_FFFF;
                    ubusy[k] = 1'b1;
                    timer[k] = lat[k];
                end else if (ubusy[k]) begin
                    timer[k]--;
                    if (timer[k] <= 0) begin
                        ubusy[k]            = 1'b0;
                        u_done[k]           = 1'b1;
                        u_be[k*EW +: EW]    = pend[k][31:16];
                        u_bseq[k*SW +: SW]  = pend[k][15:0];
                    end
                end
                if (stray_req[k]) begin
                    stray_req[k]       = 1'b0;
                    u_done[k]          = 1'b1;
                    u_be[k*EW +: EW]   = '0;
                    u_bseq[k*SW +: SW] = '0;
                end
            end
            u_idle[k] = uen[k] && !ubusy[k] && !u_done[k];
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int u1_acks;
        rst_n     = 1'b0;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        cfg_first = '0;
        cfg_last  = '0;
        cfg_chunk = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_aborted", aborted_o, 1'b0);
        check("rst_best_e", best_e_o, 16'hFFFF);
        check("rst_best_seq", best_seq_o, 16'h0);
        check("rst_unit_start", unit_start_o, 2'b00);
        check("rst_unit_ack", unit_ack_o, 2'b00);
        check("rst_state", dbg_state_o, 2'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic job: three chunks, two units finishing together, tie-breaking on seq.
        ack_log.delete();
        expect_disp(0, 16'd0, 16'd4);
        expect_disp(1, 16'd4, 16'd4);
        expect_disp(0, 16'd8, 16'd2);
        add_res(16'd5, 16'd3);
        add_res(16'd2, 16'd7);
        add_res(16'd2, 16'd1);
        start_job(16'd0, 16'd9, 16'd4);
        check("j1_busy", busy_o, 1'b1);
        check("j1_best_e_init", best_e_o, 16'hFFFF);
        check("j1_state_dispatch", dbg_state_o, 2'd1);
        wait_done("j1_done");
        check("j1_busy_end", busy_o, 1'b0);
        check("j1_err", err_o, 1'b0);
        check("j1_aborted", aborted_o, 1'b0);
        check("j1_best_e", best_e_o, 16'd2);
        check("j1_best_seq", best_seq_o, 16'd1);
        check("j1_all_dispatched", exp_q.size(), 0);
        check("j1_ack_count", ack_log.size(), 3);
        if (ack_log.size() >= 2) begin
            check("j1_first_ack_unit0", ack_log[0] % 4, 0);
            check("j1_unit1_ack_next_cycle", ack_log[1] - ack_log[0], 5);
        end

        // Top of range: single chunk, no pointer wrap.
        expect_disp(1, 16'hFFF0, 16'd16);
        add_res(16'd7, 16'hFFF5);
        start_job(16'hFFF0, 16'hFFFF, 16'h0020);
        wait_done("j2_done");
        check("j2_best_e", best_e_o, 16'd7);
        check("j2_best_seq", best_seq_o, 16'hFFF5);
        check("j2_all_dispatched", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check("j2_no_extra_start", unit_start_o, 2'b00);
        check("j2_done_held", done_o, 1'b1);

        // Zero chunk behaves as one; equal energy resolved to the lower sequence.
        expect_disp(0, 16'd3, 16'd1);
        expect_disp(1, 16'd4, 16'd1);
        add_res(16'd100, 16'd4);
        add_res(16'd100, 16'd3);
        start_job(16'd3, 16'd4, 16'd0);
        wait_done("j3_done");
        check("j3_best_e", best_e_o, 16'd100);
        check("j3_best_seq", best_seq_o, 16'd3);
        check("j3_all_dispatched", exp_q.size(), 0);

        // Inverted bounds: immediate error completion.
        start_job(16'd5, 16'd4, 16'd1);
        check("j4_err", err_o, 1'b1);
        check("j4_done", done_o, 1'b1);
        check("j4_busy", busy_o, 1'b0);
        check("j4_best_e", best_e_o, 16'hFFFF);
        repeat (2) @(negedge clk);
        check("j4_no_start", unit_start_o, 2'b00);

        // Abort after the first dispatch, plus a stray result that must be discarded.
        uen[1] = 1'b0;
        lat[0] = 6;
        repeat (2) @(negedge clk);
        ack_log.delete();
        expect_disp(0, 16'd0, 16'd10);
        add_res(16'd9, 16'd3);
        start_job(16'd0, 16'd99, 16'd10);
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("j5_first_dispatch", exp_q.size(), 0);
        cfg_abort    = 1'b1;
        stray_req[1] = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        wait_done("j5_done");
        check("j5_aborted", aborted_o, 1'b1);
        check("j5_err", err_o, 1'b0);
        check("j5_best_e", best_e_o, 16'd9);
        check("j5_best_seq", best_seq_o, 16'd3);
        u1_acks = 0;
        foreach (ack_log[i]) if (ack_log[i] % 4 == 1) u1_acks++;
        check("j5_stray_acked", u1_acks, 1);
        check("j5_ack_total", ack_log.size(), 2);
        uen[1] = 1'b1;
        lat[0] = 3;

        // Asynchronous reset while dispatching.
        uen[0] = 1'b0;
        uen[1] = 1'b0;
        repeat (2) @(negedge clk);
        start_job(16'd0, 16'd99, 16'd10);
        @(negedge clk);
        check("j6_pre_reset_state", dbg_state_o, 2'd1);
        check("j6_pre_reset_busy", busy_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("j6_rst_state", dbg_state_o, 2'd0);
        check("j6_rst_busy", busy_o, 1'b0);
        check("j6_rst_done", done_o, 1'b0);
        check("j6_rst_best_e", best_e_o, 16'hFFFF);
        check("j6_rst_start", unit_start_o, 2'b00);
        check("j6_rst_ack", unit_ack_o, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("j6_idle_after_reset", dbg_state_o, 2'd0);
        check("final_no_pending_dispatch", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
